alu_seq_unit: RTL
=================

# alu_seq_unit

Multi-cycle execution unit that consumes the 3-bit ALUControl code produced by the ALU decoder and computes the result over a valid/ready handshake. Logic ops complete in one cycle; shifts iterate one bit position per cycle, replacing the wide barrel shifter. Sits between the decode/operand-fetch stage and write-back in the multi-cycle RISC-V datapath.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- ALUControl  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SHL, 111 SHR
- SrcA  in  WIDTH  operand A
- SrcB  in  WIDTH  operand B; shifts use SrcB[SHW-1:0] only
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- ALUResult  out  WIDTH  registered result
- Zero  out  1  registered, 1 when ALUResult == 0

## Operation
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- Accept: in_valid && in_ready at rising edge. ALUControl, SrcA, SrcB are captured; later input changes are ignored until the next accept.
- IDLE, accept, non-shift op: result registered, go to DONE.
  - ADD: A+B mod 2^WIDTH.
  - SUB: A−B mod 2^WIDTH.
  - AND, OR, XOR: bitwise.
  - SLT: signed two's-complement compare; result 1 zero-extended, else 0.
- IDLE, accept, shift op:
  - Working register loaded with SrcA; counter loaded with SrcB[SHW-1:0].
  - Counter 0: go directly to DONE with result = SrcA.
  - Else go to SHIFT.
- SHIFT: each cycle shift working register 1 bit, zero-filled. SHL is left; SHR is logical right with no sign fill. Decrement counter; on the cycle the counter reaches 0, go to DONE.
- DONE: hold ALUResult/Zero stable. out_ready high → IDLE.
- Zero is updated in the same cycle ALUResult is written.
- Not pipelined: a new request is never accepted in DONE or SHIFT, even if out_ready is high.
- Undefined codes: none; all 8 encodings are legal.

## Timing
- Reset (rst_n low, async): state IDLE, out_valid 0, ALUResult 0, Zero 0, counter 0. in_ready goes 1 immediately (combinational from state).
- Reset mid-SHIFT or in DONE aborts the operation; no result is ever presented for it.
- Latency from accept edge to out_valid high:
  - Non-shift, or shift with amount 0: 1 cycle.
  - Shift by n (1 ≤ n ≤ WIDTH−1): 1 + n cycles.
- Result leaves on the edge where out_valid && out_ready. in_ready rises the following cycle.
- Best-case throughput: one op per 2 cycles.
- out_valid, once high, stays high with a stable result until out_ready is sampled high. Backpressure has unbounded duration.
- in_valid while busy: the request is ignored, and the requester must hold it until in_ready.

## Test plan
- Reset, then ADD A=0xFFFFFFFF, B=1, out_ready=1 → out_valid one cycle after accept, ALUResult=0, Zero=1; in_ready back to 1 one cycle later.
- SUB A=5, B=7 → 0xFFFFFFFE, Zero=0. SLT A=0xFFFFFFFF (−1), B=1 → 1. SLT A=1, B=0xFFFFFFFF → 0.
- SHL A=0x1, B=0x25 (shamt 5) → out_valid exactly 6 cycles after accept, result 0x20. SHR A=0x80000000, shamt 31 → 0x1 after 32 cycles. Shift with shamt 0 → result = A after 1 cycle.
- Backpressure: XOR A=0xF0F0, B=0xFFFF with out_ready=0 for 10 cycles → out_valid and 0x0F0F held stable; in_ready=0 throughout. An in_valid pulse during this time is not accepted.
- Input stability: change SrcA/ALUControl during SHIFT → result reflects the values captured at accept.
- Async reset asserted mid-SHIFT (shamt 20, cycle 7) → out_valid=0, ALUResult=0, in_ready=1 immediately. Next op AND 0xFF00/0x0FF0 → 0x0F00, no stale output.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU. Logic and arithmetic ops finish in one cycle. Shifts move one bit
// per cycle through a working register, so no barrel shifter is needed.
module alu_seq_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic             dir_reg, dir_next;   // 1 = logical right, 0 = left
  logic             zero_reg, zero_next;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] shifted;
  logic             is_shift;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign ALUResult = result_reg;
  assign Zero      = zero_reg;
  assign is_shift  = (ALUControl[2:1] == 2'b11);
  assign shifted   = dir_reg ? {1'b0, work_reg[WIDTH-1:1]} : {work_reg[WIDTH-2:0], 1'b0};

  always_comb begin
    logic_res = '0;
    case (ALUControl)
      3'b000:  logic_res = SrcA + SrcB;
      3'b001:  logic_res = SrcA - SrcB;
      3'b010:  logic_res = SrcA & SrcB;
      3'b011:  logic_res = SrcA | SrcB;
      3'b100:  logic_res = SrcA ^ SrcB;
      3'b101:  logic_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    zero_next   = zero_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (is_shift) begin
            work_next = SrcA;
            cnt_next  = SrcB[SHW-1:0];
            dir_next  = ALUControl[0];
            if (SrcB[SHW-1:0] == '0) begin
              result_next = SrcA;
              zero_next   = (SrcA == '0);
              state_next  = DONE;
            end else begin
              state_next = SHIFT;
            end
          end else begin
            result_next = logic_res;
            zero_next   = (logic_res == '0);
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        work_next = shifted;
        cnt_next  = cnt_reg - SHW'(1);
        // Last step: publish the shifted value together with its Zero flag.
        if (cnt_reg == SHW'(1)) begin
          result_next = shifted;
          zero_next   = (shifted == '0);
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      zero_reg   <= zero_next;
    end
  end

endmodule
